// File: rtl/alu_pipe.sv
// Registered ALU with a valid/ready handshake. Single-cycle ops deliver one cycle after accept;
// MUL runs a WIDTH-step shift-and-add sequence and delivers WIDTH+1 cycles after accept.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       word,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       alu_flagReg,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state;
  logic [3:0]         op;
  logic               accept;
  logic               is_mul;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHW-1:0]     amt;
  logic               amt_big;
  logic [WIDTH-1:0]   res_p0;
  logic [3:0]         flg_p0;
  logic               c_p0;
  logic               v_p0;
  logic               cmp_p0;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               unused_bits;

  assign op          = word[7:4];
  assign unused_bits = ^word[3:0];
  assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign is_mul      = (op == 4'b0001);
  assign sum         = {1'b0, in1} + {1'b0, in2};
  assign diff        = {1'b0, in2} - {1'b0, in1};
  assign amt         = in1[SHW-1:0];
  assign amt_big     = (int'(amt) >= WIDTH);

  // Stage p0: combinational evaluation of every single-cycle opcode
  always_comb begin
    res_p0 = in2;
    c_p0   = 1'b0;
    v_p0   = 1'b0;
    cmp_p0 = 1'b0;
    case (op)
      4'b0100, 4'b1100: begin
        res_p0 = sum[WIDTH-1:0];
        c_p0   = sum[WIDTH];
        v_p0   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      4'b0101, 4'b1101: begin
        res_p0 = diff[WIDTH-1:0];
        c_p0   = diff[WIDTH];
        v_p0   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in2[WIDTH-1]);
      end
      4'b0110, 4'b1110: res_p0 = in1 & in2;
      4'b1000, 4'b1001: res_p0 = in1 | in2;
      4'b1010, 4'b1011: res_p0 = in1 ^ in2;
      4'b0111, 4'b1111: begin
        res_p0 = diff[WIDTH-1:0];
        c_p0   = (in1 < in2);
        cmp_p0 = 1'b1;
      end
      4'b0010: res_p0 = amt_big ? '0 : (in2 << amt);
      4'b0011: res_p0 = amt_big ? '0 : (in2 >> amt);
      default: res_p0 = in2;
    endcase
    // CMP reports equality on the operands rather than on the difference
    flg_p0 = {v_p0,
              cmp_p0 ? 1'b0 : res_p0[WIDTH-1],
              c_p0,
              cmp_p0 ? (in1 == in2) : (res_p0 == '0)};
  end

  // Stage p1: result/flag registers, handshake and multiply sequencer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      out         <= '0;
      alu_flagReg <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
    end else begin
      if ((state == DONE) || (accept && !is_mul))
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state  <= MUL;
              busy   <= 1'b1;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, in2};
              mplier <= in1;
              cnt    <= '0;
            end else begin
              out         <= res_p0;
              alu_flagReg <= flg_p0;
            end
          end
        end
        MUL: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          out         <= acc[WIDTH-1:0];
          alu_flagReg <= {1'b0, acc[WIDTH-1], |acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:0] == '0};
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): expected {out,flags} are queued at issue time
// and popped when the corresponding result is handed off.
module tb_alu_pipe;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       word;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       alu_flagReg;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  // {word, in1, in2, expected out, expected {V,N,C,Z}}
  localparam logic [35:0] TBL [19] = '{
    36'h40F020102, 36'h500505001, 36'h700307042, 36'h200181020, 36'h300780010,
    36'hC57F0180C, 36'hD00603FD6, 36'h5A01807F8, 36'h60F03C300, 36'hE00FF0001,
    36'h800F808F4, 36'hB0FFFF001, 36'hA0550F5A0, 36'h0012A5A54, 36'hF00909001,
    36'h708001810, 36'h900000001, 36'h200F03804, 36'h40808000B
  };

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .word       (word),
    .in1        (in1),
    .in2        (in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .alu_flagReg(alu_flagReg),
    .busy       (busy)
  );

  task automatic issue(input logic [7:0] w, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eo, input logic [3:0] ef, input bit push);
    word = w; in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) exp_q.push_back({eo, ef});
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; word = '0; in1 = '0; in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out, alu_flagReg} !== 12'h000) begin
      failures++;
      $display("FAIL reset_data: out=%h flags=%b expected out=00 flags=0000", out, alu_flagReg);
    end
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_single_cycle;
    logic [11:0] e;
    for (int i = 0; i < 19; i++) begin
      issue(TBL[i][35:28], TBL[i][27:20], TBL[i][19:12], TBL[i][11:4], TBL[i][3:0], 1'b1);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL op%0d_latency: out_valid=%b expected 1", i, out_valid);
      end
      e = exp_q.pop_front();
      checks++;
      if ({out, alu_flagReg} !== e) begin
        failures++;
        $display("FAIL op%0d_result: out=%h flags=%b expected out=%h flags=%b",
                 i, out, alu_flagReg, e[11:4], e[3:0]);
      end
    end
  endtask

  task automatic test_mul;
    logic [11:0] e;
    int idx;
    int nbusy;
    for (int m = 0; m < 2; m++) begin
      if (m == 0) issue(8'h10, 8'h0D, 8'h0B, 8'h8F, 4'b0100, 1'b1);
      else        issue(8'h1F, 8'h10, 8'h10, 8'h00, 4'b0011, 1'b1);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL mul%0d_in_ready: in_ready=%b expected 0", m, in_ready);
      end
      idx = 0; nbusy = 0;
      while (out_valid !== 1'b1 && idx < 40) begin
        if (busy === 1'b1) nbusy++;
        @(posedge clk); #1;
        idx++;
      end
      checks++;
      if (idx !== 9) begin
        failures++;
        $display("FAIL mul%0d_latency: cycles=%0d expected 9", m, idx);
      end
      checks++;
      if (nbusy !== 8) begin
        failures++;
        $display("FAIL mul%0d_busy: busy_cycles=%0d expected 8", m, nbusy);
      end
      e = exp_q.pop_front();
      checks++;
      if ({out, alu_flagReg} !== e) begin
        failures++;
        $display("FAIL mul%0d_result: out=%h flags=%b expected out=%h flags=%b",
                 m, out, alu_flagReg, e[11:4], e[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] e;
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(8'h40, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b1);
    e = exp_q[0];
    word = 8'h40; in1 = 8'h10; in2 = 8'h10; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({in_ready, out_valid, out, alu_flagReg} !== {2'b01, e}) begin
        failures++;
        $display("FAIL stall%0d: in_ready=%b out_valid=%b out=%h flags=%b expected 0 1 %h %b",
                 c, in_ready, out_valid, out, alu_flagReg, e[11:4], e[3:0]);
      end
      @(posedge clk); #1;
    end
    word = 8'h50; in1 = 8'h01; in2 = 8'h09; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({8'h08, 4'b0000});
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL drain_accept_valid: out_valid=%b expected 1", out_valid);
    end
    e = exp_q.pop_front();
    checks++;
    if ({out, alu_flagReg} !== e) begin
      failures++;
      $display("FAIL drain_accept_result: out=%h flags=%b expected out=%h flags=%b",
               out, alu_flagReg, e[11:4], e[3:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignored_request: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [11:0] e;
    int seen;
    issue(8'h10, 8'h0D, 8'h0B, 8'h00, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mul_busy_before_reset: busy=%b expected 1", busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out, alu_flagReg, out_valid, busy} !== 14'h0) begin
      failures++;
      $display("FAIL mid_mul_reset: out=%h flags=%b out_valid=%b busy=%b expected 00 0000 0 0",
               out, alu_flagReg, out_valid, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready: in_ready=%b expected 1", in_ready);
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL aborted_mul_result: valid_cycles=%0d expected 0", seen);
    end
    issue(8'h00, 8'h33, 8'h5A, 8'h5A, 4'b0000, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if ({out_valid, out, alu_flagReg} !== {1'b1, e}) begin
      failures++;
      $display("FAIL post_reset_op: out_valid=%b out=%h flags=%b expected 1 %h %b",
               out_valid, out, alu_flagReg, e[11:4], e[3:0]);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_empty: pending=%0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
